// File: rtl/plru_fill_way_select.sv
// -----------------------------------------------------------------------------
// plru_fill_way_select
//
// Chooses the victim way for refills in a 4-way set-associative data cache.
// Each set has a 3-bit tree-PLRU state and a 4-bit valid vector. The block
// turns refill requests into a registered one-cycle write-enable pulse and a
// 2-bit way index. These outputs drive the cache's 1-to-4 way-enable demux:
// fill_we goes to its data_in and fill_way goes to its select.
//
// Tree encoding per set (plru[2:0]):
//   plru[0] = b0 (root: 0 -> left pair {0,1}, 1 -> right pair {2,3})
//   plru[1] = b1 (ways 0/1: 0 -> way0, 1 -> way1)
//   plru[2] = b2 (ways 2/3: 0 -> way2, 1 -> way3)
// The bits point toward the next victim. A touch flips the bits on the
// touched way's path so they point away from that way.
//
// Ports:
//   clk            in   system clock, rising edge
//   rst            in   synchronous active-high reset, clears all state
//   access_en      in   hit touched access_way in access_set this cycle
//   access_set     in   [IDX_W] set index of the touch
//   access_way     in   [2] way touched
//   fill_en        in   refill request for fill_set (block picks the way)
//   fill_set       in   [IDX_W] set index of the refill
//   invalidate_all in   flush: clears every valid bit, drops a concurrent fill
//   lookup_set     in   [IDX_W] set whose current victim is reported
//   victim_way     out  [2] combinational victim for lookup_set
//   set_full       out  combinational, all four ways of lookup_set valid
//   fill_we        out  registered one-cycle pulse after an accepted fill
//   fill_way       out  [2] registered way of the last accepted fill
//   fill_set_q     out  [IDX_W] registered set of the last accepted fill
// -----------------------------------------------------------------------------
module plru_fill_way_select #(
    parameter int  NUM_SETS = 4,
    localparam int IDX_W    = $clog2(NUM_SETS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             access_en,
    input  logic [IDX_W-1:0] access_set,
    input  logic [1:0]       access_way,
    input  logic             fill_en,
    input  logic [IDX_W-1:0] fill_set,
    input  logic             invalidate_all,
    input  logic [IDX_W-1:0] lookup_set,
    output logic [1:0]       victim_way,
    output logic             set_full,
    output logic             fill_we,
    output logic [1:0]       fill_way,
    output logic [IDX_W-1:0] fill_set_q
);

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    // Victim choice: invalid ways come first, lowest index wins. If all four
    // ways are valid, follow the tree bits.
    function automatic logic [1:0] victim_f(input logic [2:0] plru,
                                            input logic [3:0] valid);
        logic [1:0] way;
        if (!valid[0]) begin
            way = 2'd0;
        end else if (!valid[1]) begin
            way = 2'd1;
        end else if (!valid[2]) begin
            way = 2'd2;
        end else if (!valid[3]) begin
            way = 2'd3;
        end else if (!plru[0]) begin
            way = plru[1] ? 2'd1 : 2'd0;
        end else begin
            way = plru[2] ? 2'd3 : 2'd2;
        end
        return way;
    endfunction

    // Touch update: the root and the touched pair's bit point away from the
    // touched way. The other pair's bit keeps its value.
    function automatic logic [2:0] touch_f(input logic [2:0] plru,
                                           input logic [1:0] way);
        logic [2:0] nxt;
        nxt = plru;
        case (way)
            2'd0: begin
                nxt[0] = 1'b1;
                nxt[1] = 1'b1;
            end
            2'd1: begin
                nxt[0] = 1'b1;
                nxt[1] = 1'b0;
            end
            2'd2: begin
                nxt[0] = 1'b0;
                nxt[2] = 1'b1;
            end
            2'd3: begin
                nxt[0] = 1'b0;
                nxt[2] = 1'b0;
            end
            default: begin
                nxt = plru;
            end
        endcase
        return nxt;
    endfunction

    // One-hot decode of a way index, used to set a single valid bit.
    function automatic logic [3:0] way_onehot_f(input logic [1:0] way);
        logic [3:0] oh;
        case (way)
            2'd0:    oh = 4'b0001;
            2'd1:    oh = 4'b0010;
            2'd2:    oh = 4'b0100;
            2'd3:    oh = 4'b1000;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [2:0]       plru_q      [NUM_SETS];
    logic [2:0]       plru_d      [NUM_SETS];
    logic [2:0]       plru_acc_s  [NUM_SETS];
    logic [3:0]       valid_q     [NUM_SETS];
    logic [3:0]       valid_d     [NUM_SETS];

    logic             fill_ok_s;
    logic [1:0]       fill_victim_s;

    logic             fill_we_q;
    logic             fill_we_d;
    logic [1:0]       fill_way_q;
    logic [1:0]       fill_way_d;
    logic [IDX_W-1:0] fill_set_hold_q;
    logic [IDX_W-1:0] fill_set_hold_d;

    // A flush in the same cycle drops the refill completely.
    assign fill_ok_s = fill_en & ~invalidate_all;

    // The fill victim always comes from pre-edge state, even when an access
    // to the same set lands in the same cycle.
    assign fill_victim_s = victim_f(plru_q[fill_set], valid_q[fill_set]);

    // Per-set next state. The access touch is applied first and the fill
    // touch second, so the fill's bits win where the two paths overlap.
    always_comb begin
        for (int s = 0; s < NUM_SETS; s++) begin
            plru_acc_s[s] = (access_en && (access_set == IDX_W'(s)))
                          ? touch_f(plru_q[s], access_way)
                          : plru_q[s];

            plru_d[s] = (fill_ok_s && (fill_set == IDX_W'(s)))
                      ? touch_f(plru_acc_s[s], fill_victim_s)
                      : plru_acc_s[s];

            if (invalidate_all) begin
                valid_d[s] = 4'b0000;
            end else if (fill_ok_s && (fill_set == IDX_W'(s))) begin
                valid_d[s] = valid_q[s] | way_onehot_f(fill_victim_s);
            end else begin
                valid_d[s] = valid_q[s];
            end
        end
    end

    // Next values of the fill outputs. The way and set keep their last
    // values between pulses.
    always_comb begin
        fill_we_d = fill_ok_s;
        if (fill_ok_s) begin
            fill_way_d      = fill_victim_s;
            fill_set_hold_d = fill_set;
        end else begin
            fill_way_d      = fill_way_q;
            fill_set_hold_d = fill_set_hold_q;
        end
    end

    // PLRU and valid state registers. Reset clears every set.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                plru_q[s]  <= 3'b000;
                valid_q[s] <= 4'b0000;
            end
        end else begin
            for (int s = 0; s < NUM_SETS; s++) begin
                plru_q[s]  <= plru_d[s];
                valid_q[s] <= valid_d[s];
            end
        end
    end

    // Fill output registers. Reset takes priority and suppresses any pulse
    // from a fill in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_we_q       <= 1'b0;
            fill_way_q      <= 2'd0;
            fill_set_hold_q <= {IDX_W{1'b0}};
        end else begin
            fill_we_q       <= fill_we_d;
            fill_way_q      <= fill_way_d;
            fill_set_hold_q <= fill_set_hold_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign victim_way = victim_f(plru_q[lookup_set], valid_q[lookup_set]);
    assign set_full   = &valid_q[lookup_set];
    assign fill_we    = fill_we_q;
    assign fill_way   = fill_way_q;
    assign fill_set_q = fill_set_hold_q;

endmodule

// File: tb/tb_plru_fill_way_select.sv
// -----------------------------------------------------------------------------
// Testbench for plru_fill_way_select. A driver issues directed and random
// stimulus and updates a reference model of the cache replacement state. For
// each accepted fill the driver queues the expected pulse. A separate monitor
// checks the fill outputs and the lookup outputs on every falling edge.
// -----------------------------------------------------------------------------
module tb_plru_fill_way_select;

    localparam int NS = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          access_en = 1'b0;
    logic [IW-1:0] access_set = '0;
    logic [1:0]    access_way = 2'd0;
    logic          fill_en = 1'b0;
    logic [IW-1:0] fill_set = '0;
    logic          invalidate_all = 1'b0;
    logic [IW-1:0] lookup_set = '0;
    logic [1:0]    victim_way;
    logic          set_full;
    logic          fill_we;
    logic [1:0]    fill_way;
    logic [IW-1:0] fill_set_q;

    always #5 clk = ~clk;

    plru_fill_way_select #(.NUM_SETS(NS)) dut (
        .clk            (clk),
        .rst            (rst),
        .access_en      (access_en),
        .access_set     (access_set),
        .access_way     (access_way),
        .fill_en        (fill_en),
        .fill_set       (fill_set),
        .invalidate_all (invalidate_all),
        .lookup_set     (lookup_set),
        .victim_way     (victim_way),
        .set_full       (set_full),
        .fill_we        (fill_we),
        .fill_way       (fill_way),
        .fill_set_q     (fill_set_q)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        int way;
        int set;
    } fill_t;

    fill_t exp_q[$];

    // Reference model: the tree pointer bits and the valid flags for each set.
    int b0[NS];
    int b1[NS];
    int b2[NS];
    bit vld[NS][4];
    int hold_way = 0;
    int hold_set = 0;
    bit mon_on   = 1'b0;

    task automatic check(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int mvictim(int s);
        for (int w = 0; w < 4; w++) begin
            if (!vld[s][w]) return w;
        end
        return b0[s] * 2 + (b0[s] != 0 ? b2[s] : b1[s]);
    endfunction

    function automatic int mfull(int s);
        int n = 0;
        for (int w = 0; w < 4; w++) n += vld[s][w];
        return (n == 4) ? 1 : 0;
    endfunction

    task automatic mtouch(int s, int w);
        if (w < 2) begin
            b0[s] = 1;
            b1[s] = (w == 0) ? 1 : 0;
        end else begin
            b0[s] = 0;
            b2[s] = (w == 2) ? 1 : 0;
        end
    endtask

    // Apply one cycle of inputs, then advance the model past the edge.
    task automatic step(bit r, bit ae, int as, int aw, bit fe, int fs, bit inv, int ls);
        int    v;
        fill_t e;
        rst            = r;
        access_en      = ae;
        access_set     = IW'(as);
        access_way     = 2'(aw);
        fill_en        = fe;
        fill_set       = IW'(fs);
        invalidate_all = inv;
        lookup_set     = IW'(ls);
        @(posedge clk);
        #1;
        if (r) begin
            for (int s = 0; s < NS; s++) begin
                b0[s] = 0;
                b1[s] = 0;
                b2[s] = 0;
                for (int w = 0; w < 4; w++) vld[s][w] = 1'b0;
            end
            hold_way = 0;
            hold_set = 0;
            mon_on   = 1'b1;
        end else begin
            v = mvictim(fs);
            if (ae) mtouch(as, aw);
            if (fe && !inv) begin
                mtouch(fs, v);
                vld[fs][v] = 1'b1;
                e.way = v;
                e.set = fs;
                exp_q.push_back(e);
                hold_way = v;
                hold_set = fs;
            end
            if (inv) begin
                for (int s = 0; s < NS; s++)
                    for (int w = 0; w < 4; w++) vld[s][w] = 1'b0;
            end
        end
        rst = 1'b0;
    endtask

    task automatic idle(int ls);
        step(1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b0, ls);
    endtask

    task automatic fill(int fs, int ls);
        step(1'b0, 1'b0, 0, 0, 1'b1, fs, 1'b0, ls);
    endtask

    task automatic expect_vf(string nm, int s, int v, int f);
        lookup_set = IW'(s);
        #1;
        check({nm, "_victim"}, int'(victim_way), v);
        check({nm, "_full"}, int'(set_full), f);
    endtask

    task automatic expect_we_next(string nm, int we, int way);
        @(negedge clk);
        #1;
        check({nm, "_we"}, int'(fill_we), we);
        if (we != 0) check({nm, "_way"}, int'(fill_way), way);
    endtask

    // Monitor: compare the fill outputs with the queued expectations, and the
    // lookup outputs with the model.
    initial begin : monitor
        fill_t e;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                if (fill_we) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_pulse: got fill_we=1 expected 0 at %0t", $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("fill_way", int'(fill_way), e.way);
                        check("fill_set_q", int'(fill_set_q), e.set);
                    end
                end else begin
                    if (exp_q.size() != 0) begin
                        total++;
                        bad++;
                        $display("FAIL missing_pulse: got fill_we=0 expected 1 at %0t", $time);
                        e = exp_q.pop_front();
                    end else begin
                        check("hold_way", int'(fill_way), hold_way);
                        check("hold_set", int'(fill_set_q), hold_set);
                    end
                end
                check("victim_way", int'(victim_way), mvictim(int'(lookup_set)));
                check("set_full", int'(set_full), mfull(int'(lookup_set)));
            end
        end
    end

    initial begin : driver
        // Reset state.
        step(1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b0, 0);
        expect_vf("reset", 0, 0, 0);

        // Four fills to set 0, then a fifth one.
        for (int i = 0; i < 4; i++) fill(0, 0);
        expect_vf("four_fills", 0, 0, 1);
        fill(0, 0);
        expect_vf("fifth_fill", 0, 2, 1);

        // Access sequence on a full set 0 with a cleared tree.
        step(1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b0, 0);
        for (int i = 0; i < 4; i++) fill(0, 0);
        step(1'b0, 1'b1, 0, 0, 1'b0, 0, 1'b0, 0);
        expect_vf("acc_w0", 0, 2, 1);
        step(1'b0, 1'b1, 0, 2, 1'b0, 0, 1'b0, 0);
        expect_vf("acc_w2", 0, 1, 1);
        step(1'b0, 1'b1, 0, 1, 1'b0, 0, 1'b0, 0);
        expect_vf("acc_w1", 0, 3, 1);

        // Same-cycle access and fill to a full set 1.
        for (int i = 0; i < 4; i++) fill(1, 1);
        step(1'b0, 1'b1, 1, 3, 1'b1, 1, 1'b0, 1);
        expect_vf("acc_fill", 1, 2, 1);
        expect_we_next("acc_fill", 1, 0);

        // Flush with a concurrent fill.
        step(1'b0, 1'b0, 0, 0, 1'b1, 2, 1'b1, 2);
        for (int s = 0; s < NS; s++) expect_vf("flush", s, 0, 0);
        expect_we_next("flush", 0, 0);

        // Reset in the cycle after a fill, with another fill request present.
        fill(3, 3);
        step(1'b1, 1'b0, 0, 0, 1'b1, 3, 1'b0, 3);
        expect_we_next("rst_after_fill", 0, 0);
        expect_vf("rst_after_fill", 3, 0, 0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 1) == 1),
                 $urandom_range(0, NS - 1),
                 $urandom_range(0, 3),
                 ($urandom_range(0, 9) < 4),
                 $urandom_range(0, NS - 1),
                 ($urandom_range(0, 49) == 0),
                 $urandom_range(0, NS - 1));
        end

        idle(0);
        idle(1);
        @(negedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
